// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: STAGES carry-save slices with operand skew and result de-skew.
// Define PIPELINED_ADDER_FLAGS_EN to register the zero/negative flags; otherwise they are tied to 0.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_operandA,
  input  logic [WIDTH-1:0] i_operandB,
  input  logic             i_carry,
  input  logic             i_sub,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_overflow,
  output logic             o_zero,
  output logic             o_negative,
  output logic             o_valid,
  input  logic             i_ready
);

  localparam int SW   = (STAGES > 0) ? WIDTH / STAGES : 1;
  localparam int LAST = STAGES - 1;

  if (STAGES < 1 || WIDTH < 2 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be >= 2 and an integer multiple of STAGES");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  assign advance = ~valid_q | i_ready;
  // A reset cycle always reports ready: whatever is presented is dropped with the flushed pipe.
  assign o_ready = advance | ~i_reset;
  assign b_eff   = i_sub ? ~i_operandB : i_operandB;
  assign cin_eff = i_carry ^ i_sub;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int LEFT_W = WIDTH - k * SW;
    localparam int DONE_W = (k + 1) * SW;

    logic [LEFT_W-1:0] a_src, b_src;
    logic              c_src, v_src, sub_src;
    logic [SW:0]       sum;
    logic [DONE_W-1:0] res_sum;

    if (k == 0) begin : g_in
      assign a_src   = i_operandA;
      assign b_src   = b_eff;
      assign c_src   = cin_eff;
      assign v_src   = i_valid;
      assign sub_src = i_sub;
      assign res_sum = sum[SW-1:0];
    end else begin : g_in
      assign a_src   = stg[k-1].g_reg.a_q;
      assign b_src   = stg[k-1].g_reg.b_q;
      assign c_src   = stg[k-1].g_reg.c_q;
      assign v_src   = stg[k-1].g_reg.v_q;
      assign sub_src = stg[k-1].g_reg.sub_q;
      assign res_sum = {sum[SW-1:0], stg[k-1].g_reg.r_q};
    end

    assign sum = {1'b0, a_src[SW-1:0]} + {1'b0, b_src[SW-1:0]} + {{SW{1'b0}}, c_src};

    if (k < LAST) begin : g_reg
      localparam int REST_W = LEFT_W - SW;

      logic              v_q, v_d, c_q, c_d, sub_q, sub_d;
      logic [DONE_W-1:0] r_q, r_d;
      logic [REST_W-1:0] a_q, a_d, b_q, b_d;

      // NOTE: every always_comb output gets its hold value first, so no path can infer a latch.
      always_comb begin
        v_d   = v_q;
        c_d   = c_q;
        sub_d = sub_q;
        r_d   = r_q;
        a_d   = a_q;
        b_d   = b_q;
        if (advance) begin
          v_d   = v_src;
          c_d   = sum[SW];
          sub_d = sub_src;
          r_d   = res_sum;
          a_d   = a_src[LEFT_W-1:SW];
          b_d   = b_src[LEFT_W-1:SW];
        end
      end

      always_ff @(posedge i_clock) begin
        if (!i_reset) v_q <= 1'b0;
        else          v_q <= v_d;
      end

      // NOTE: skew/de-skew data needs no reset; the cleared valid bit already marks it as garbage.
      always_ff @(posedge i_clock) begin
        c_q   <= c_d;
        sub_q <= sub_d;
        r_q   <= r_d;
        a_q   <= a_d;
        b_q   <= b_d;
      end
    end
  end

  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    if (advance) begin
      valid_d  = stg[LAST].v_src;
      result_d = stg[LAST].res_sum;
      carry_d  = stg[LAST].sum[SW] ^ stg[LAST].sub_src;
      ovf_d    = (stg[LAST].a_src[SW-1] == stg[LAST].b_src[SW-1]) &
                 (stg[LAST].res_sum[WIDTH-1] != stg[LAST].a_src[SW-1]);
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_result   = result_q;
  assign o_carry    = carry_q;
  assign o_overflow = ovf_q;

`ifdef PIPELINED_ADDER_FLAGS_EN
  logic zero_q, zero_d, neg_q, neg_d;

  always_comb begin
    zero_d = zero_q;
    neg_d  = neg_q;
    if (advance) begin
      zero_d = (stg[LAST].res_sum == '0);
      neg_d  = stg[LAST].res_sum[WIDTH-1];
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end

  assign o_zero     = zero_q;
  assign o_negative = neg_q;
`else
  assign o_zero     = 1'b0;
  assign o_negative = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (WIDTH=32, STAGES=4); flag expectations follow
// whether PIPELINED_ADDER_FLAGS_EN is defined for the build.
module tb_pipelined_adder;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic [31:0] i_operandA, i_operandB;
  logic        i_carry, i_sub, i_valid, i_ready;
  logic        o_ready, o_carry, o_overflow, o_zero, o_negative, o_valid;
  logic [31:0] o_result;

  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_operandA(i_operandA),
    .i_operandB(i_operandB),
    .i_carry   (i_carry),
    .i_sub     (i_sub),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_result  (o_result),
    .o_carry   (o_carry),
    .o_overflow(o_overflow),
    .o_zero    (o_zero),
    .o_negative(o_negative),
    .o_valid   (o_valid),
    .i_ready   (i_ready)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [31:0] a, b;
    logic        cin, sub;
    logic [35:0] exp;
  } vec_t;

  vec_t        vecs[12];
  int          n_vec  = 0;
  int          n_fail = 0;
  logic [31:0] sa[10], sb[10];
  logic        scin[10], ssub[10];
  logic [35:0] sexp[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [35:0] pack(input logic [31:0] r, input logic c, input logic v,
                                       input logic z, input logic n);
`ifdef PIPELINED_ADDER_FLAGS_EN
    return {r, c, v, z, n};
`else
    return {r, c, v, 2'b00};
`endif
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic cin,
                              input logic sub, input logic [31:0] r, input logic c,
                              input logic v, input logic z, input logic n);
    vec_t t;
    t.a = a; t.b = b; t.cin = cin; t.sub = sub;
    t.exp = pack(r, c, v, z, n);
    return t;
  endfunction

  // Reference: unsigned 33-bit arithmetic for carry/borrow, signed 64-bit for overflow.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    logic [32:0] u;
    longint      s;
    logic        ovf;
    if (!sub) begin
      u = {1'b0, a} + {1'b0, b} + {32'b0, cin};
      s = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    end else begin
      u = {1'b0, a} - {1'b0, b} - {32'b0, cin};
      s = longint'($signed(a)) - longint'($signed(b)) - longint'(cin);
    end
    ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return pack(u[31:0], u[32], ovf, u[31:0] == 32'd0, u[31]);
  endfunction

  function automatic logic [35:0] obs();
    return {o_result, o_carry, o_overflow, o_zero, o_negative};
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic sub);
    i_operandA = a; i_operandB = b; i_carry = cin; i_sub = sub;
  endtask

  initial begin
    int lat, iss, rcv, stall_left, last_cyc, seen;
    bit stalled;
    logic [35:0] snap;

    //            a             b             cin   sub   result        c     ovf   z     n
    vecs[0]  = mk(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[1]  = mk(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
    vecs[2]  = mk(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[3]  = mk(32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    vecs[4]  = mk(32'h0000FFFF, 32'h00000001, 1'b1, 1'b0, 32'h00010001, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mk(32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[6]  = mk(32'h00000005, 32'h00000005, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[7]  = mk(32'h00000005, 32'h00000005, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    vecs[8]  = mk(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[9]  = mk(32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[10] = mk(32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, 32'h01000100, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[11] = mk(32'h00000001, 32'h00000002, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 10; i++) begin
      sa[i] = $urandom; sb[i] = $urandom;
      scin[i] = 1'($urandom_range(0, 1)); ssub[i] = 1'($urandom_range(0, 1));
      sexp[i] = model(sa[i], sb[i], scin[i], ssub[i]);
    end

    // Reset state
    i_reset = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge i_clock);
    check("reset_ready", o_ready, 1);
    @(posedge i_clock); #1;
    @(negedge i_clock);
    check("reset_valid", o_valid, 0);
    check("reset_fields", obs(), 36'd0);
    @(posedge i_clock); #1;
    i_reset = 1'b1;
    @(posedge i_clock); #1;

    // Directed vectors, one at a time: latency and every output field
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      i_valid = 1'b1;
      @(posedge i_clock); #1;
      i_valid = 1'b0;
      lat = 0;
      for (int c = 1; c <= 10; c++) begin
        @(negedge i_clock);
        if (o_valid) begin
          lat = c;
          break;
        end
        @(posedge i_clock);
      end
      check($sformatf("vec%0d_latency", i), lat, 4);
      check($sformatf("vec%0d_fields", i), obs(), vecs[i].exp);
      @(posedge i_clock); #1;
    end

    // Back-to-back stream with a 3-cycle downstream stall on the 2nd result
    iss = 0; rcv = 0; stall_left = 0; stalled = 0; last_cyc = -1; snap = '0;
    for (int cyc = 0; cyc < 200 && rcv < 10; cyc++) begin
      if (!stalled && o_valid && rcv == 1) begin
        stalled = 1; stall_left = 3; snap = obs();
      end
      i_ready = (stall_left == 0);
      i_valid = (iss < 10);
      if (iss < 10) drive(sa[iss], sb[iss], scin[iss], ssub[iss]);
      @(negedge i_clock);
      if (stall_left > 0) begin
        check("stall_ready", o_ready, 0);
        if (stall_left < 3) check("stall_hold", {o_valid, obs()}, {1'b1, snap});
        stall_left--;
      end
      if (i_valid && o_ready) iss++;
      if (o_valid && i_ready) begin
        check($sformatf("stream%0d", rcv), obs(), sexp[rcv]);
        rcv++;
        last_cyc = cyc;
      end
      @(posedge i_clock); #1;
    end
    i_valid = 1'b0; i_ready = 1'b1;
    check("stream_count", rcv, 10);
    check("stream_last_cycle", last_cyc, 16);

    // Reset while three operations are in flight behind a stalled result
    i_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(32'h100 + k, 32'h1, 1'b0, 1'b0);
      i_valid = 1'b1;
      @(posedge i_clock); #1;
    end
    i_valid = 1'b0;
    @(negedge i_clock);
    check("pre_reset_state", {o_valid, o_ready}, 2'b10);
    @(posedge i_clock); #1;
    i_reset = 1'b0;
    i_valid = 1'b1;
    drive(32'h55, 32'h22, 1'b0, 1'b0);
    @(negedge i_clock);
    check("reset_ready_busy", o_ready, 1);
    @(posedge i_clock); #1;
    i_reset = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    @(negedge i_clock);
    check("post_reset_valid", o_valid, 0);
    check("post_reset_fields", obs(), 36'd0);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge i_clock); #1;
      @(negedge i_clock);
      if (o_valid) seen++;
    end
    check("no_stale_results", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
